// File: rtl/fifo_pkg.sv
// Shared FIFO types: the read-mode enum and a helper that sizes the occupancy counter.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // The counter must hold every value 0..depth inclusive, hence depth+1.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for param_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; stale words are unreachable because the
    // pointers and level are cleared, and a reset here would block RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with arbitrary depth, standard or first-word-fall-through read,
// level-based flags and sticky overflow/underflow indicators.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AF_THRESH  = DEPTH - 2,
    parameter int         AE_THRESH  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                rd_valid,
    output logic                                full,
    output logic                                empty,
    output logic                                almost_full,
    output logic                                almost_empty,
    output logic [level_width(DEPTH)-1:0]       level,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

    if (DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_params
        $error("param_fifo: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_mem_wr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == FULL_LVL);
    assign w_pop_ok  = rd_en && !w_empty;
    assign w_push_ok = wr_en && (!w_full || w_pop_ok);
    // flush wins over a simultaneous push, and the array is left untouched.
    assign w_mem_wr  = w_push_ok && !flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_mem_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (wdata),
        .rd_addr (r_rd_ptr),
        .rd_data (w_mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (wr_en && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_WIDTH-1:0] r_rdata;
        logic                  r_rd_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rdata    <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_pop_ok && !flush;
                if (w_pop_ok && !flush) begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end

        assign rdata    = r_rdata;
        assign rd_valid = r_rd_valid;
    end else begin : g_fwft
        // Head word is shown straight from the array; masked to zero while empty
        // so reset and flush leave a defined value on the bus.
        assign rdata    = w_empty ? '0 : w_mem_rdata;
        assign rd_valid = !w_empty;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= AF_LVL);
    assign almost_empty = (r_level <= AE_LVL);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
